// File: rtl/shift_pipe.sv
// shift_pipe: two-stage LSL/LSR/ASR/ROR shifter with valid/ready handshake and whole-pipe stall.
// Define SHIFT_PIPE_ROR_EN to build the rotate mode; otherwise mode 11 behaves as LSR.
module shift_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    input  logic [3:0]       shift_hex,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] value_out,
    output logic             carry_out,
    output logic             oversize
);
    localparam int SW = $clog2(WIDTH);
    // wide enough that lo + shift_hex never wraps, even for narrow datapaths
    localparam int AW = (SW + 1 > 5) ? SW + 1 : 5;
    logic             w_adv;
    logic [SW-1:0]    w_lo;
    logic [AW-1:0]    w_amt;
    logic             w_ovf;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_v1;
    logic [1:0]       r_mode;
    logic [SW-1:0]    r_sh;
    logic             r_ovf;
    logic [WIDTH:0]   w_lsl;
    logic [WIDTH:0]   w_lsr;
    logic [WIDTH:0]   w_asr;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    assign w_adv = EN & (~out_valid | out_ready);
    assign in_ready = w_adv;
    assign w_lo = value2[SW-1:0];
    assign w_amt = (w_lo == '0) ? AW'(shift_hex) + AW'(1) : AW'(w_lo) + AW'(shift_hex);
    assign w_ovf = (|value2[WIDTH-1:SW]) | (w_amt >= AW'(WIDTH));
    // an extra bit alongside the operand catches the last bit shifted out
    assign w_lsl = {1'b0, r_v1} << r_sh;
    assign w_lsr = {r_v1, 1'b0} >> r_sh;
    assign w_asr = $signed({r_v1, 1'b0}) >>> r_sh;
`ifdef SHIFT_PIPE_ROR_EN
    logic [WIDTH-1:0] w_ror;
    assign w_ror = (r_v1 >> r_sh) | (r_v1 << (WIDTH - int'(r_sh)));
`endif
    always_comb begin
        w_res = '0;
        w_c = 1'b0;
        case (r_mode)
            2'b00: {w_c, w_res} = r_ovf ? '0 : w_lsl;
            2'b10: {w_res, w_c} = r_ovf ? {(WIDTH + 1){r_v1[WIDTH-1]}} : w_asr;
`ifdef SHIFT_PIPE_ROR_EN
            2'b11: begin
                w_res = w_ror;
                w_c = (r_sh != '0) & w_ror[WIDTH-1];
            end
`endif
            default: {w_res, w_c} = r_ovf ? '0 : w_lsr;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_v1 <= '0;
            r_mode <= '0;
            r_sh <= '0;
            r_ovf <= 1'b0;
            out_valid <= 1'b0;
            value_out <= '0;
            carry_out <= 1'b0;
            oversize <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_v1 <= value1;
            r_mode <= mode;
            r_sh <= w_amt[SW-1:0];
            r_ovf <= w_ovf;
            out_valid <= r_s1_valid;
            value_out <= w_res;
            carry_out <= w_c;
            oversize <= r_ovf;
        end
    end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed vectors for shift_pipe covering modes, oversize, backpressure, reset and EN stalls.
module tb_shift_pipe;
    logic        clk;
    logic        rst;
    logic        EN;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value1;
    logic [31:0] value2;
    logic [3:0]  shift_hex;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] value_out;
    logic        carry_out;
    logic        oversize;
    int          n_tests;
    int          n_fails;

    shift_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .EN(EN), .in_valid(in_valid), .in_ready(in_ready),
        .value1(value1), .value2(value2), .shift_hex(shift_hex), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .value_out(value_out),
        .carry_out(carry_out), .oversize(oversize)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] hx, input logic [1:0] md);
        value1 = v1;
        value2 = v2;
        shift_hex = hx;
        mode = md;
    endtask

    task automatic run_op(input string tag, input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] hx,
                          input logic [1:0] md, input logic [31:0] eo, input logic ec, input logic ev);
        drive(v1, v2, hx, md);
        in_valid = 1'b1;
        chk({tag, ".rdy"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        chk({tag, ".early"}, out_valid, 0);
        step();
        chk({tag, ".vld"}, out_valid, 1);
        chk({tag, ".val"}, value_out, eo);
        chk({tag, ".c"}, carry_out, ec);
        chk({tag, ".ovf"}, oversize, ev);
    endtask

    initial begin
        n_tests = 0;
        n_fails = 0;
        rst = 1'b1;
        EN = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        drive(0, 0, 0, 0);
        step();
        step();
        chk("rst.vld", out_valid, 0);
        chk("rst.val", value_out, 0);
        chk("rst.c", carry_out, 0);
        chk("rst.ovf", oversize, 0);
        chk("rst.rdy", in_ready, 1);
        rst = 1'b0;
        step();

        run_op("asr1", 32'h8000_0000, 0, 0, 2'b10, 32'hC000_0000, 0, 0);
        run_op("lsr5", 32'h0000_00F0, 3, 2, 2'b01, 32'h0000_0007, 1, 0);
        run_op("lsl32", 32'h1, 31, 1, 2'b00, 32'h0, 0, 1);
        run_op("asr_hi", 32'h8000_0001, 32'h20, 0, 2'b10, 32'hFFFF_FFFF, 1, 1);
        run_op("lsr_hi", 32'h8000_0001, 32'h20, 0, 2'b01, 32'h0, 0, 1);
        run_op("lsl1", 32'h8000_0001, 0, 0, 2'b00, 32'h0000_0002, 1, 0);
        run_op("lsl16", 32'h0001_FFFF, 0, 15, 2'b00, 32'hFFFF_0000, 1, 0);
        run_op("asr16", 32'hFFFF_8000, 0, 15, 2'b10, 32'hFFFF_FFFF, 1, 0);
        run_op("lsr31", 32'h8000_0000, 16, 15, 2'b01, 32'h0000_0001, 0, 0);
        run_op("asr32", 32'h7FFF_FFFF, 31, 1, 2'b10, 32'h0, 0, 1);
`ifdef SHIFT_PIPE_ROR_EN
        run_op("ror4", 32'h1, 4, 0, 2'b11, 32'h1000_0000, 0, 0);
        run_op("ror36", 32'h0000_00F8, 31, 5, 2'b11, 32'h8000_000F, 1, 1);
        run_op("ror32", 32'h1234_5678, 17, 15, 2'b11, 32'h1234_5678, 0, 1);
`else
        run_op("ror4", 32'h1, 4, 0, 2'b11, 32'h0, 0, 0);
        run_op("ror36", 32'h0000_00F8, 31, 5, 2'b11, 32'h0, 0, 1);
        run_op("ror32", 32'h1234_5678, 17, 15, 2'b11, 32'h0, 0, 1);
        run_op("ror_lsr", 32'h0000_0030, 0, 4, 2'b11, 32'h0000_0001, 1, 0);
`endif
        step();

        // backpressure: four beats, each LSL by 1 of k+1
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(1, 0, 0, 2'b00);
        chk("bp.rdy0", in_ready, 1);
        step();
        drive(2, 0, 0, 2'b00);
        chk("bp.rdy1", in_ready, 1);
        step();
        drive(3, 0, 0, 2'b00);
        chk("bp.stall_rdy", in_ready, 0);
        chk("bp.stall_vld", out_valid, 1);
        chk("bp.hold0", value_out, 2);
        step();
        chk("bp.hold1", value_out, 2);
        chk("bp.stall_rdy1", in_ready, 0);
        step();
        chk("bp.hold2", value_out, 2);
        chk("bp.hold2_vld", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("bp.resume_rdy", in_ready, 1);
        step();
        chk("bp.out1", value_out, 4);
        drive(4, 0, 0, 2'b00);
        step();
        chk("bp.out2", value_out, 6);
        in_valid = 1'b0;
        step();
        chk("bp.out3", value_out, 8);
        chk("bp.out3_vld", out_valid, 1);
        step();
        chk("bp.drain", out_valid, 0);

        // asynchronous reset with two beats in flight
        in_valid = 1'b1;
        drive(32'h10, 0, 0, 2'b00);
        step();
        drive(32'h20, 0, 0, 2'b00);
        step();
        in_valid = 1'b0;
        chk("ar.pre_vld", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.vld", out_valid, 0);
        chk("ar.val", value_out, 0);
        step();
        rst = 1'b0;
        step();
        chk("ar.flushed", out_valid, 0);
        run_op("ar.new", 32'h8000_0000, 0, 3, 2'b10, 32'hF800_0000, 0, 0);
        step();

        // EN low for three cycles mid-stream
        in_valid = 1'b1;
        drive(32'h10, 0, 0, 2'b00);
        step();
        drive(32'h20, 0, 0, 2'b00);
        step();
        drive(32'h30, 0, 0, 2'b00);
        EN = 1'b0;
        #1;
        chk("en.rdy", in_ready, 0);
        chk("en.p", value_out, 32'h20);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en.hold", value_out, 32'h20);
            chk("en.hold_vld", out_valid, 1);
        end
        EN = 1'b1;
        #1;
        chk("en.resume_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("en.q", value_out, 32'h40);
        step();
        chk("en.r", value_out, 32'h60);
        chk("en.r_vld", out_valid, 1);
        step();
        chk("en.drain", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule
